// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared definitions for the privileged trap sequencer.
// Contents:
//   - architectural cause codes and machine interrupt indices
//   - mtvec mode encoding
//   - sequencer state and latched event kind enums
package trap_ctrl_pkg;

    localparam int unsigned CAUSE_ILLEGAL = 2;
    localparam int unsigned CAUSE_ECALL_U = 8;   // ecall cause = CAUSE_ECALL_U + priv_mode
    localparam int unsigned IRQ_MSI       = 3;
    localparam int unsigned IRQ_MTI       = 7;
    localparam int unsigned IRQ_MEI       = 11;

    typedef enum logic [1:0] {
        MTVEC_DIRECT   = 2'd0,
        MTVEC_VECTORED = 2'd1,
        MTVEC_RSVD2    = 2'd2,
        MTVEC_RSVD3    = 2'd3
    } mtvec_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_COMMIT = 2'd2
    } trap_state_t;

    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_TRAP = 2'd1,   // interrupt, illegal or ecall: CSR file takes a trap
        EV_MRET = 2'd2,
        EV_CSR  = 2'd3    // serializing CSR write: flush/redirect only
    } ev_kind_t;

endpackage

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: commit-stage / CSR-file bundle around the trap sequencer.
// Signals:
//   commit_*      decoded instruction at the commit boundary
//   mem_busy      outstanding data-bus traffic
//   mstatus_mie, mie, mip, mtvec, mepc, priv_mode   CSR file state
//   stall_commit, flush, redirect_valid, redirect_pc   pipeline control
//   trap_we, mret_we, trap_cause, trap_epc, trap_tval  CSR file update
//   busy          sequencer not idle
// Modports: slave = trap_ctrl, master = the surrounding pipeline / CSR file.
interface trap_ctrl_if #(
    parameter int XLEN = 64
);
    logic            commit_valid;
    logic [XLEN-1:0] commit_pc;
    logic            commit_is_ecall;
    logic            commit_is_mret;
    logic            commit_is_csr;
    logic            commit_illegal;
    logic [31:0]     commit_instr;
    logic            mem_busy;
    logic            mstatus_mie;
    logic [XLEN-1:0] mie;
    logic [XLEN-1:0] mip;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [1:0]      priv_mode;

    logic            stall_commit;
    logic            flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            trap_we;
    logic            mret_we;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_epc;
    logic [XLEN-1:0] trap_tval;
    logic            busy;

    modport slave (
        input  commit_valid, commit_pc, commit_is_ecall, commit_is_mret,
               commit_is_csr, commit_illegal, commit_instr, mem_busy,
               mstatus_mie, mie, mip, mtvec, mepc, priv_mode,
        output stall_commit, flush, redirect_valid, redirect_pc, trap_we,
               mret_we, trap_cause, trap_epc, trap_tval, busy
    );

    modport master (
        output commit_valid, commit_pc, commit_is_ecall, commit_is_mret,
               commit_is_csr, commit_illegal, commit_instr, mem_busy,
               mstatus_mie, mie, mip, mtvec, mepc, priv_mode,
        input  stall_commit, flush, redirect_valid, redirect_pc, trap_we,
               mret_we, trap_cause, trap_epc, trap_tval, busy
    );
endinterface

// File: rtl/trap_ctrl_irq_prio.sv
// trap_irq_prio: combinational machine interrupt priority encoder.
// Ports:
//   mip, mie   in   pending / enable CSR values
//   irq_valid  out  some supported interrupt is pending and enabled
//   irq_index  out  winning interrupt index, MEI > MSI > MTI
module trap_irq_prio
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] mip,
    input  logic [XLEN-1:0] mie,
    output logic            irq_valid,
    output logic [3:0]      irq_index
);
    logic [XLEN-1:0] pend;
    logic            unused_pend;

    assign pend = mip & mie;
    // Only the three machine-level sources are implemented here.
    assign unused_pend = ^{pend[XLEN-1:12], pend[10:8], pend[6:4], pend[2:0]};

    always_comb begin
        irq_valid = 1'b0;
        irq_index = '0;
        if (pend[IRQ_MEI]) begin
            irq_valid = 1'b1;
            irq_index = 4'(IRQ_MEI);
        end else if (pend[IRQ_MSI]) begin
            irq_valid = 1'b1;
            irq_index = 4'(IRQ_MSI);
        end else if (pend[IRQ_MTI]) begin
            irq_valid = 1'b1;
            irq_index = 4'(IRQ_MTI);
        end
    end
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: privileged control-flow sequencer between commit and the CSR file.
// Picks one event per commit boundary (interrupt > illegal > ecall > mret >
// CSR write), stalls commit, waits for memory to drain, then issues a single
// CSR update strobe with flush and fetch redirect.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   bus          trap_ctrl_if.slave bundle (commit inputs, CSR values,
//                stall/flush/redirect and trap/mret strobes with values)
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN            = 64,
    parameter bit IRQ_VECTORED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    trap_ctrl_if.slave  bus
);
    trap_state_t     state_q, state_d;
    ev_kind_t        kind_q, kind_d;
    logic [XLEN-1:0] cause_q, epc_q, tval_q, target_q;
    logic [XLEN-1:0] cause_d, epc_d, tval_d, target_d;
    logic [XLEN-1:0] base;
    logic            irq_valid, irq_take, latch;
    logic [3:0]      irq_index;

    trap_irq_prio #(.XLEN(XLEN)) u_irq_prio (
        .mip       (bus.mip),
        .mie       (bus.mie),
        .irq_valid (irq_valid),
        .irq_index (irq_index)
    );

    // Event decode for the instruction at the commit boundary
    always_comb begin
        // M-mode interrupts are always enabled from lower privilege levels.
        irq_take = irq_valid && ((bus.priv_mode != 2'b11) || bus.mstatus_mie);
        base     = bus.mtvec & ~XLEN'(3);
        kind_d   = EV_NONE;
        cause_d  = '0;
        epc_d    = bus.commit_pc;
        tval_d   = '0;
        target_d = base;
        if (irq_take) begin
            kind_d             = EV_TRAP;
            cause_d            = XLEN'(irq_index);
            cause_d[XLEN-1]    = 1'b1;
            if (IRQ_VECTORED_EN && (mtvec_mode_t'(bus.mtvec[1:0]) == MTVEC_VECTORED))
                target_d = base + XLEN'({irq_index, 2'b00});
        end else if (bus.commit_illegal) begin
            kind_d  = EV_TRAP;
            cause_d = XLEN'(CAUSE_ILLEGAL);
            tval_d  = XLEN'(bus.commit_instr);
        end else if (bus.commit_is_ecall) begin
            kind_d  = EV_TRAP;
            cause_d = XLEN'(CAUSE_ECALL_U) + XLEN'(bus.priv_mode);
        end else if (bus.commit_is_mret) begin
            kind_d   = EV_MRET;
            target_d = bus.mepc;
        end else if (bus.commit_is_csr) begin
            kind_d   = EV_CSR;
            target_d = bus.commit_pc + XLEN'(4);
        end
    end

    // Sequencer next state and outputs
    always_comb begin
        state_d            = state_q;
        latch              = 1'b0;
        bus.stall_commit   = 1'b0;
        bus.flush          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.trap_we        = 1'b0;
        bus.mret_we        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Held off during reset so nothing is latched or stalled.
                if (!reset && bus.commit_valid && (kind_d != EV_NONE)) begin
                    bus.stall_commit = 1'b1;
                    latch            = 1'b1;
                    state_d          = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                bus.stall_commit = 1'b1;
                if (!bus.mem_busy)
                    state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                bus.stall_commit   = 1'b1;
                bus.flush          = 1'b1;
                bus.redirect_valid = 1'b1;
                bus.trap_we        = (kind_q == EV_TRAP);
                bus.mret_we        = (kind_q == EV_MRET);
                state_d            = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        bus.redirect_pc = bus.redirect_valid ? target_q : '0;
        bus.trap_cause  = bus.trap_we ? cause_q : '0;
        bus.trap_epc    = bus.trap_we ? epc_q   : '0;
        bus.trap_tval   = bus.trap_we ? tval_q  : '0;
        bus.busy        = (state_q != ST_IDLE);
    end

    // State and latched event registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            kind_q  <= EV_NONE;
        end else begin
            state_q <= state_d;
            if (latch)
                kind_q <= kind_d;
        end
    end

    // Event payload is only observed while gated by the strobes above.
    always_ff @(posedge clk) begin
        if (latch) begin
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            tval_q   <= tval_d;
            target_q <= target_d;
        end
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed self-checking bench for trap_ctrl.
module tb_trap_ctrl;
    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   strobes = 0;

    always #5 clk = ~clk;

    trap_ctrl_if #(.XLEN(XLEN)) bus ();

    trap_ctrl #(.XLEN(XLEN), .IRQ_VECTORED_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(negedge clk) if (bus.trap_we || bus.mret_we) strobes++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_in();
        bus.commit_valid    = 1'b0;
        bus.commit_pc       = '0;
        bus.commit_is_ecall = 1'b0;
        bus.commit_is_mret  = 1'b0;
        bus.commit_is_csr   = 1'b0;
        bus.commit_illegal  = 1'b0;
        bus.commit_instr    = '0;
        bus.mem_busy        = 1'b0;
        bus.mstatus_mie     = 1'b0;
        bus.mie             = '0;
        bus.mip             = '0;
        bus.mtvec           = 64'h8000_0000;
        bus.mepc            = '0;
        bus.priv_mode       = 2'd3;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_in();
        next(); next();
        smp();
        n_cmp++; if ({bus.stall_commit, bus.flush, bus.redirect_valid, bus.trap_we, bus.mret_we, bus.busy} !== 6'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b want 000000", {bus.stall_commit, bus.flush, bus.redirect_valid, bus.trap_we, bus.mret_we, bus.busy}); end
        n_cmp++; if ({bus.redirect_pc, bus.trap_cause, bus.trap_epc, bus.trap_tval} !== 256'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {bus.redirect_pc, bus.trap_cause, bus.trap_epc, bus.trap_tval}); end
        next();
        reset = 1'b0;
        next();
    endtask

    task automatic test_ecall();
        bus.commit_valid = 1'b1; bus.commit_is_ecall = 1'b1; bus.priv_mode = 2'd3;
        bus.commit_pc = 64'h8000_0100; bus.mtvec = 64'h8000_0000;
        smp();
        n_cmp++; if (bus.stall_commit !== 1'b1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL ecall_T_stall: got stall=%b busy=%b want 1 0", bus.stall_commit, bus.busy); end
        next();
        bus.commit_valid = 1'b0; bus.commit_is_ecall = 1'b0;
        bus.mtvec = 64'h9000_0000;   // must be ignored in DRAIN
        smp();
        n_cmp++; if (bus.busy !== 1'b1 || bus.trap_we !== 1'b0 || bus.stall_commit !== 1'b1) begin n_bad++; $display("FAIL ecall_drain: got busy=%b we=%b stall=%b want 1 0 1", bus.busy, bus.trap_we, bus.stall_commit); end
        next(); smp();
        n_cmp++; if (bus.trap_we !== 1'b1 || bus.mret_we !== 1'b0) begin n_bad++; $display("FAIL ecall_we: got trap_we=%b mret_we=%b want 1 0", bus.trap_we, bus.mret_we); end
        n_cmp++; if (bus.trap_cause !== 64'd11) begin n_bad++; $display("FAIL ecall_cause: got %h want b", bus.trap_cause); end
        n_cmp++; if (bus.trap_epc !== 64'h8000_0100 || bus.trap_tval !== 64'h0) begin n_bad++; $display("FAIL ecall_epc_tval: got %h %h want 80000100 0", bus.trap_epc, bus.trap_tval); end
        n_cmp++; if (bus.redirect_pc !== 64'h8000_0000 || bus.flush !== 1'b1 || bus.redirect_valid !== 1'b1) begin n_bad++; $display("FAIL ecall_redirect: got pc=%h fl=%b rv=%b want 80000000 1 1", bus.redirect_pc, bus.flush, bus.redirect_valid); end
        next(); smp();
        n_cmp++; if (bus.busy !== 1'b0 || bus.trap_we !== 1'b0 || bus.stall_commit !== 1'b0 || bus.flush !== 1'b0) begin n_bad++; $display("FAIL ecall_idle: got busy=%b we=%b stall=%b fl=%b want 0 0 0 0", bus.busy, bus.trap_we, bus.stall_commit, bus.flush); end
        next();
        bus.mtvec = 64'h8000_0000;
    endtask

    task automatic test_mret_drain();
        bus.commit_valid = 1'b1; bus.commit_is_mret = 1'b1; bus.mepc = 64'h8000_0204;
        bus.commit_pc = 64'h8000_0020; bus.mem_busy = 1'b1;
        smp();
        n_cmp++; if (bus.stall_commit !== 1'b1) begin n_bad++; $display("FAIL mret_T_stall: got %b want 1", bus.stall_commit); end
        next();
        bus.commit_valid = 1'b0; bus.commit_is_mret = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) begin   // another commit during DRAIN must be ignored
                bus.commit_valid = 1'b1; bus.commit_is_ecall = 1'b1; bus.mepc = 64'h1234;
            end
            if (c == 3) begin bus.commit_valid = 1'b0; bus.commit_is_ecall = 1'b0; end
            if (c == 4) bus.mem_busy = 1'b0;
            smp();
            n_cmp++; if (bus.mret_we !== 1'b0 || bus.trap_we !== 1'b0 || bus.busy !== 1'b1 || bus.flush !== 1'b0) begin n_bad++; $display("FAIL mret_wait_T+%0d: got mret=%b trap=%b busy=%b fl=%b want 0 0 1 0", c, bus.mret_we, bus.trap_we, bus.busy, bus.flush); end
            next();
        end
        smp();
        n_cmp++; if (bus.mret_we !== 1'b1 || bus.trap_we !== 1'b0 || bus.trap_cause !== 64'h0) begin n_bad++; $display("FAIL mret_T+5_we: got mret=%b trap=%b cause=%h want 1 0 0", bus.mret_we, bus.trap_we, bus.trap_cause); end
        n_cmp++; if (bus.redirect_pc !== 64'h8000_0204 || bus.flush !== 1'b1 || bus.redirect_valid !== 1'b1) begin n_bad++; $display("FAIL mret_redirect: got pc=%h fl=%b rv=%b want 80000204 1 1", bus.redirect_pc, bus.flush, bus.redirect_valid); end
        next(); smp();
        n_cmp++; if (bus.busy !== 1'b0 || bus.mret_we !== 1'b0) begin n_bad++; $display("FAIL mret_idle: got busy=%b mret=%b want 0 0", bus.busy, bus.mret_we); end
        next();
        bus.mepc = '0;
    endtask

    task automatic run_irq(input string nm, input logic [63:0] mip, input logic [63:0] mie,
                           input logic [63:0] mtvec, input logic [1:0] priv, input logic gmie,
                           input logic exp_take, input logic [63:0] exp_cause, input logic [63:0] exp_tgt);
        bus.commit_valid = 1'b1; bus.commit_pc = 64'h8000_0300;
        bus.mip = mip; bus.mie = mie; bus.mtvec = mtvec; bus.priv_mode = priv; bus.mstatus_mie = gmie;
        smp();
        n_cmp++; if (bus.stall_commit !== exp_take) begin n_bad++; $display("FAIL %s_stall: got %b want %b", nm, bus.stall_commit, exp_take); end
        next();
        bus.commit_valid = 1'b0; bus.mip = '0; bus.mie = '0;
        smp();
        n_cmp++; if (bus.busy !== exp_take) begin n_bad++; $display("FAIL %s_busy: got %b want %b", nm, bus.busy, exp_take); end
        next(); smp();
        n_cmp++; if (bus.trap_we !== exp_take) begin n_bad++; $display("FAIL %s_we: got %b want %b", nm, bus.trap_we, exp_take); end
        if (exp_take) begin
            n_cmp++; if (bus.trap_cause !== exp_cause || bus.trap_epc !== 64'h8000_0300 || bus.trap_tval !== 64'h0) begin n_bad++; $display("FAIL %s_vals: got cause=%h epc=%h tval=%h want %h 80000300 0", nm, bus.trap_cause, bus.trap_epc, bus.trap_tval, exp_cause); end
            n_cmp++; if (bus.redirect_pc !== exp_tgt) begin n_bad++; $display("FAIL %s_target: got %h want %h", nm, bus.redirect_pc, exp_tgt); end
        end
        next();
        bus.mstatus_mie = 1'b0; bus.priv_mode = 2'd3; bus.mtvec = 64'h8000_0000;
    endtask

    task automatic test_irq();
        run_irq("mti_vec", 64'h80, 64'h80, 64'h8000_0001, 2'd3, 1'b1, 1'b1, 64'h8000_0000_0000_0007, 64'h8000_001C);
        run_irq("mti_masked", 64'h80, 64'h80, 64'h8000_0001, 2'd3, 1'b0, 1'b0, 64'h0, 64'h0);
        run_irq("mei_prio_u", 64'h888, 64'h888, 64'h8000_0001, 2'd0, 1'b0, 1'b1, 64'h8000_0000_0000_000B, 64'h8000_002C);
        run_irq("msi_mode2", 64'h88, 64'h08, 64'h8000_0002, 2'd3, 1'b1, 1'b1, 64'h8000_0000_0000_0003, 64'h8000_0000);
    endtask

    task automatic test_illegal_ecall();
        bus.commit_valid = 1'b1; bus.commit_illegal = 1'b1; bus.commit_is_ecall = 1'b1;
        bus.commit_instr = 32'hFFFF_FFFF; bus.priv_mode = 2'd0;
        bus.commit_pc = 64'h8000_0400; bus.mtvec = 64'h8000_0001;
        next();
        bus.commit_valid = 1'b0; bus.commit_illegal = 1'b0; bus.commit_is_ecall = 1'b0; bus.commit_instr = '0;
        next(); smp();
        n_cmp++; if (bus.trap_we !== 1'b1 || bus.trap_cause !== 64'd2) begin n_bad++; $display("FAIL illegal_cause: got we=%b cause=%h want 1 2", bus.trap_we, bus.trap_cause); end
        n_cmp++; if (bus.trap_tval !== 64'h0000_0000_FFFF_FFFF || bus.trap_epc !== 64'h8000_0400) begin n_bad++; $display("FAIL illegal_tval_epc: got %h %h want ffffffff 80000400", bus.trap_tval, bus.trap_epc); end
        n_cmp++; if (bus.redirect_pc !== 64'h8000_0000) begin n_bad++; $display("FAIL illegal_target: got %h want 80000000", bus.redirect_pc); end
        next();
        bus.priv_mode = 2'd3; bus.mtvec = 64'h8000_0000;
    endtask

    task automatic test_back_to_back();
        bus.commit_valid = 1'b1; bus.commit_is_csr = 1'b1; bus.commit_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        next();
        bus.commit_valid = 1'b0; bus.commit_is_csr = 1'b0;
        next(); smp();
        n_cmp++; if (bus.flush !== 1'b1 || bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 64'h0) begin n_bad++; $display("FAIL csr_wrap: got fl=%b rv=%b pc=%h want 1 1 0", bus.flush, bus.redirect_valid, bus.redirect_pc); end
        n_cmp++; if (bus.trap_we !== 1'b0 || bus.mret_we !== 1'b0) begin n_bad++; $display("FAIL csr_no_strobe: got trap=%b mret=%b want 0 0", bus.trap_we, bus.mret_we); end
        next();
        // first IDLE cycle: accept a new event immediately
        bus.commit_valid = 1'b1; bus.commit_is_ecall = 1'b1; bus.priv_mode = 2'd1; bus.commit_pc = 64'h8000_0500;
        smp();
        n_cmp++; if (bus.stall_commit !== 1'b1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_accept: got stall=%b busy=%b want 1 0", bus.stall_commit, bus.busy); end
        next();
        bus.commit_valid = 1'b0; bus.commit_is_ecall = 1'b0;
        next(); smp();
        n_cmp++; if (bus.trap_we !== 1'b1 || bus.trap_cause !== 64'd9 || bus.trap_epc !== 64'h8000_0500) begin n_bad++; $display("FAIL b2b_ecall_s: got we=%b cause=%h epc=%h want 1 9 80000500", bus.trap_we, bus.trap_cause, bus.trap_epc); end
        next();
        bus.priv_mode = 2'd3;
    endtask

    task automatic test_reset_drain();
        int s0;
        bus.commit_valid = 1'b1; bus.commit_is_ecall = 1'b1; bus.mem_busy = 1'b1; bus.commit_pc = 64'h8000_0600;
        next();
        bus.commit_valid = 1'b0; bus.commit_is_ecall = 1'b0;
        reset = 1'b1;
        smp();
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rstd_in_drain: got busy=%b want 1", bus.busy); end
        next();
        smp();
        s0 = strobes;
        n_cmp++; if ({bus.stall_commit, bus.flush, bus.redirect_valid, bus.trap_we, bus.mret_we, bus.busy} !== 6'b0) begin n_bad++; $display("FAIL rstd_ctrl: got %b want 000000", {bus.stall_commit, bus.flush, bus.redirect_valid, bus.trap_we, bus.mret_we, bus.busy}); end
        n_cmp++; if ({bus.redirect_pc, bus.trap_cause, bus.trap_epc, bus.trap_tval} !== 256'h0) begin n_bad++; $display("FAIL rstd_data: got %h want 0", {bus.redirect_pc, bus.trap_cause, bus.trap_epc, bus.trap_tval}); end
        next();
        reset = 1'b0; bus.mem_busy = 1'b0;
        repeat (4) next();
        smp();
        n_cmp++; if (strobes !== s0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL rstd_no_strobe: got strobes=%0d busy=%b want %0d 0", strobes, bus.busy, s0); end
        next();
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_mret_drain();
        test_irq();
        test_illegal_ecall();
        test_back_to_back();
        test_reset_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
